adc_multi_monitor: RTL

Parametrised successor to the single-channel current-monitor ADC controller. It drives a serial SAR ADC (convert strobe, SCK, SDO) through an external analogue mux. It samples NUM_CH channels round-robin and compares each result against a per-channel limit, keeping live and sticky fail flags. Results are delivered to the I2C register block through a one-deep hold buffer, so a register read in progress never tears a value. Everything, including SCK, runs in the clk domain; there is no derived clock.

---
 rtl/adc_multi_monitor_pkg.sv | 21 ++
 rtl/adc_multi_monitor_if.sv | 26 ++
 rtl/adc_multi_monitor_result_hold.sv | 91 +++++++++
 rtl/adc_multi_monitor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adc_multi_monitor_pkg.sv
// Shared definitions for the multi-channel ADC monitor: frame state encoding,
// result/limit width and the channel-select width helper.
package adc_multi_monitor_pkg;

    // Results and limits are carried as 16-bit unsigned values throughout.
    localparam int LIM_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONVERT  = 3'd1,
        ST_SCK_HIGH = 3'd2,
        ST_SCK_LOW  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Channel select width; a single channel still gets a 1-bit select.
    function automatic int chw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_multi_monitor_if.sv
// ADC pin bundle plus the result bus towards the I2C register block.
// master = monitor side, slave = ADC/consumer side.
interface adc_multi_monitor_if
    import adc_multi_monitor_pkg::*;
#(
    parameter int CHW = 1
) ();
    logic             adc_convert;
    logic             adc_sck;
    logic [CHW-1:0]   adc_chsel;
    logic             adc_sdo;
    logic             data_valid;
    logic [CHW-1:0]   data_ch;
    logic [LIM_W-1:0] data_value;
    logic             hold;

    modport master (
        output adc_convert, adc_sck, adc_chsel, data_valid, data_ch, data_value,
        input  adc_sdo, hold
    );

    modport slave (
        input  adc_convert, adc_sck, adc_chsel, data_valid, data_ch, data_value,
        output adc_sdo, hold
    );
endinterface

// File: rtl/adc_multi_monitor_result_hold.sv
// Result delivery towards the register block: capture register, one-deep
// pending buffer while the consumer holds, and overrun flag. A result that
// arrives while the buffer is already full is dropped; the older one is kept.
module adc_result_hold
    import adc_multi_monitor_pkg::*;
#(
    parameter int CHW = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cap_valid_i,
    input  logic [CHW-1:0]   cap_ch_i,
    input  logic [LIM_W-1:0] cap_value_i,
    input  logic             hold_i,
    input  logic             status_clear_i,
    output logic             data_valid_o,
    output logic [CHW-1:0]   data_ch_o,
    output logic [LIM_W-1:0] data_value_o,
    output logic             overrun_o
);
    logic             out_valid_q, out_valid_d;
    logic [CHW-1:0]   out_ch_q, out_ch_d;
    logic [LIM_W-1:0] out_value_q, out_value_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CHW-1:0]   pend_ch_q, pend_ch_d;
    logic [LIM_W-1:0] pend_value_q, pend_value_d;
    logic             overrun_q, overrun_d;

    // Route each new result to the outputs, the pending slot, or the bin.
    always_comb begin
        out_valid_d  = 1'b0;
        out_ch_d     = out_ch_q;
        out_value_d  = out_value_q;
        pend_valid_d = pend_valid_q;
        pend_ch_d    = pend_ch_q;
        pend_value_d = pend_value_q;
        overrun_d    = overrun_q & ~status_clear_i;
        if (!hold_i) begin
            if (pend_valid_q) begin
                // Oldest result goes out first; a simultaneous capture refills the slot.
                out_valid_d  = 1'b1;
                out_ch_d     = pend_ch_q;
                out_value_d  = pend_value_q;
                pend_valid_d = cap_valid_i;
                if (cap_valid_i) begin
                    pend_ch_d    = cap_ch_i;
                    pend_value_d = cap_value_i;
                end
            end else if (cap_valid_i) begin
                out_valid_d = 1'b1;
                out_ch_d    = cap_ch_i;
                out_value_d = cap_value_i;
            end
        end else if (cap_valid_i) begin
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_ch_d    = cap_ch_i;
                pend_value_d = cap_value_i;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Output and buffer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_value_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_ch_q    <= '0;
            pend_value_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_value_q  <= out_value_d;
            pend_valid_q <= pend_valid_d;
            pend_ch_q    <= pend_ch_d;
            pend_value_q <= pend_value_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_valid_o = out_valid_q;
    assign data_ch_o    = out_ch_q;
    assign data_value_o = out_value_q;
    assign overrun_o    = overrun_q;

endmodule

// File: rtl/adc_multi_monitor.sv
// Round-robin serial SAR ADC sequencer with per-channel limit compare.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | one cycle; latch next channel and raise convert if enabled
// CONVERT   | convert high for CONV_CYCLES cycles
// SCK_HIGH  | sck high for SCK_DIV cycles; sample sdo on the last one
// SCK_LOW   | sck low for SCK_DIV cycles; loop until ADC_BITS pulses
// DONE      | one cycle; result captured and compared against the limit
module adc_multi_monitor
    import adc_multi_monitor_pkg::*;
#(
    parameter int ADC_BITS    = 14,
    parameter int NUM_CH      = 2,
    parameter int CONV_CYCLES = 21,
    parameter int SCK_DIV     = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable_i,
    input  logic [LIM_W*NUM_CH-1:0] limit_in_i,
    input  logic                    limit_load_i,
    input  logic                    status_clear_i,
    output logic [NUM_CH-1:0]       fail_now_o,
    output logic [NUM_CH-1:0]       fail_sticky_o,
    output logic                    overrun_o,
    adc_multi_monitor_if.master     bus
);
    localparam int             CHW     = chw(NUM_CH);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

    state_e                        state_q;
    logic [15:0]                   cnt_q;
    logic [3:0]                    bit_cnt_q;
    logic [LIM_W-1:0]              shift_q;
    logic [CHW-1:0]                ch_ptr_q;
    logic [CHW-1:0]                chsel_q;
    logic                          convert_q;
    logic                          sck_q;
    logic [NUM_CH-1:0][LIM_W-1:0]  limit_q;
    logic [NUM_CH-1:0]             fail_now_q, fail_now_d;
    logic [NUM_CH-1:0]             fail_sticky_q, fail_sticky_d;
    logic [NUM_CH-1:0]             fail_set;
    logic                          done;
    logic                          over_limit;

    // Frame sequencer: phase timing by down-counters, sdo shifted in on sck fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ch_ptr_q  <= '0;
            chsel_q   <= '0;
            convert_q <= 1'b0;
            sck_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        chsel_q   <= ch_ptr_q;
                        ch_ptr_q  <= (ch_ptr_q == LAST_CH) ? '0 : ch_ptr_q + 1'b1;
                        convert_q <= 1'b1;
                        cnt_q     <= 16'(CONV_CYCLES - 1);
                        shift_q   <= '0;
                        state_q   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (cnt_q == '0) begin
                        convert_q <= 1'b0;
                        sck_q     <= 1'b1;
                        cnt_q     <= 16'(SCK_DIV - 1);
                        bit_cnt_q <= 4'(ADC_BITS - 1);
                        state_q   <= ST_SCK_HIGH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SCK_HIGH: begin
                    if (cnt_q == '0) begin
                        shift_q <= {shift_q[LIM_W-2:0], bus.adc_sdo};
                        sck_q   <= 1'b0;
                        cnt_q   <= 16'(SCK_DIV - 1);
                        state_q <= ST_SCK_LOW;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SCK_LOW: begin
                    if (cnt_q == '0) begin
                        if (bit_cnt_q == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                            sck_q     <= 1'b1;
                            cnt_q     <= 16'(SCK_DIV - 1);
                            state_q   <= ST_SCK_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Limit registers; a load mid-frame simply applies at the next compare.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            limit_q <= '0;
        end else if (limit_load_i) begin
            limit_q <= limit_in_i;
        end
    end

    assign done       = (state_q == ST_DONE);
    assign over_limit = (shift_q > limit_q[chsel_q]);

    // Fail flags: live flag follows each result, sticky set beats a clear.
    always_comb begin
        fail_now_d = fail_now_q;
        fail_set   = '0;
        if (done) begin
            fail_now_d[chsel_q] = over_limit;
            fail_set[chsel_q]   = over_limit;
        end
        fail_sticky_d = (fail_sticky_q & ~{NUM_CH{status_clear_i}}) | fail_set;
    end

    // Fail flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fail_now_q    <= '0;
            fail_sticky_q <= '0;
        end else begin
            fail_now_q    <= fail_now_d;
            fail_sticky_q <= fail_sticky_d;
        end
    end

    logic             data_valid;
    logic [CHW-1:0]   data_ch;
    logic [LIM_W-1:0] data_value;

    adc_result_hold #(
        .CHW (CHW)
    ) u_hold (
        .clk            (clk),
        .rstn           (rstn),
        .cap_valid_i    (done),
        .cap_ch_i       (chsel_q),
        .cap_value_i    (shift_q),
        .hold_i         (bus.hold),
        .status_clear_i (status_clear_i),
        .data_valid_o   (data_valid),
        .data_ch_o      (data_ch),
        .data_value_o   (data_value),
        .overrun_o      (overrun_o)
    );

    assign bus.adc_convert = convert_q;
    assign bus.adc_sck     = sck_q;
    assign bus.adc_chsel   = chsel_q;
    assign bus.data_valid  = data_valid;
    assign bus.data_ch     = data_ch;
    assign bus.data_value  = data_value;
    assign fail_now_o      = fail_now_q;
    assign fail_sticky_o   = fail_sticky_q;

endmodule
